// File: rtl/dual_rx_pkg.sv
// dual_rx_pkg: shared state encodings, channel ids and defaults for the dual UART receive merger
package dual_rx_pkg;
   localparam int DEF_CLKS_PER_BIT = 434;
   localparam logic [7:0] DEF_HDR_CH1 = 8'hA1;
   localparam logic [7:0] DEF_HDR_CH2 = 8'hA2;
   typedef enum logic {CH1 = 1'b0, CH2 = 1'b1} ch_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      TX_IDLE, TX_HDR_START, TX_HDR_DATA, TX_HDR_STOP, TX_D_START, TX_D_DATA, TX_D_STOP
   } tx_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with a 2-flop synchronizer; pulses byte_valid for one cycle per well-framed byte
module uart_rx_core
   import dual_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   logic [1:0] sync;
   logic s, prev;
   rx_state_t st;
   logic [CW-1:0] cnt, lim;
   logic [2:0] idx;
   assign s = sync[1];
   assign lim = st == RX_START ? HALF : FULL;
   // prev resets low so a line held low through reset must rise before a start edge counts
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
         st <= RX_IDLE;
         cnt <= '0;
         idx <= '0;
         data <= '0;
         byte_valid <= 1'b0;
      end else begin
         sync <= {sync[0], rx};
         prev <= s;
         byte_valid <= 1'b0;
         cnt <= (st == RX_IDLE || cnt == lim) ? '0 : cnt + 1'b1;
         case (st)
            RX_IDLE: if (prev && !s) st <= RX_START;
            RX_START: if (cnt == HALF) st <= s ? RX_IDLE : RX_DATA;
            RX_DATA:
               if (cnt == FULL) begin
                  data <= {s, data[7:1]};
                  idx <= idx + 1'b1;
                  if (idx == 3'd7) st <= RX_STOP;
               end
            default:
               if (cnt == FULL) begin
                  byte_valid <= s;
                  st <= RX_IDLE;
               end
         endcase
      end
endmodule

// File: rtl/dual_rx_merger.sv
// dual_rx_merger: merges two UART receivers into one UART stream, each byte framed as header + data
module dual_rx_merger
   import dual_rx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [7:0] HDR_CH1      = DEF_HDR_CH1,
   parameter logic [7:0] HDR_CH2      = DEF_HDR_CH2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx1,
   input  logic rx2,
   output logic tx,
   output logic led_ch1,
   output logic led_ch2,
   output logic overrun1,
   output logic overrun2
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [7:0] rx_byte [2];
   logic [1:0] rx_valid, push, pop, ne, led, ovr;
   logic [7:0] mem [2][FIFO_DEPTH];
   logic [AW-1:0] wp [2];
   logic [AW-1:0] rp [2];
   logic [FW-1:0] cnt [2];
   ch_t rr_last, sel;
   logic si, tick, free, grant, tx_bit;
   tx_state_t st;
   logic [CW-1:0] bcnt;
   logic [2:0] idx;
   logic [7:0] sh, dreg;

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx1 (
      .clk(clk), .rst(rst), .rx(rx1), .data(rx_byte[0]), .byte_valid(rx_valid[0])
   );
   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx2 (
      .clk(clk), .rst(rst), .rx(rx2), .data(rx_byte[1]), .byte_valid(rx_valid[1])
   );

   assign ne = {cnt[1] != '0, cnt[0] != '0};
   assign tick = bcnt == CW'(CLKS_PER_BIT - 1);
   // granting on the last D_STOP cycle lets frames run back-to-back
   assign free = st == TX_IDLE || (st == TX_D_STOP && tick);
   assign grant = free && |ne;
   assign sel = &ne ? (rr_last == CH1 ? CH2 : CH1) : (ne[1] ? CH2 : CH1);
   assign si = sel == CH2;
   assign pop = grant ? (si ? 2'b10 : 2'b01) : 2'b00;
   assign tx_bit = (st == TX_HDR_START || st == TX_D_START) ? 1'b0 :
                   (st == TX_HDR_DATA || st == TX_D_DATA) ? sh[0] : 1'b1;
   assign led_ch1 = led[0];
   assign led_ch2 = led[1];
   assign overrun1 = ovr[0];
   assign overrun2 = ovr[1];

   always_comb
      for (int i = 0; i < 2; i++)
         push[i] = rx_valid[i] && (cnt[i] != FW'(FIFO_DEPTH) || pop[i]);

   always_ff @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (push[i]) mem[i][wp[i]] <= rx_byte[i];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wp[i] <= '0;
            rp[i] <= '0;
            cnt[i] <= '0;
         end
         ovr <= '0;
         led <= '0;
      end else
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wp[i] <= wp[i] + 1'b1;
            if (pop[i]) rp[i] <= rp[i] + 1'b1;
            cnt[i] <= cnt[i] + FW'(push[i]) - FW'(pop[i]);
            if (rx_valid[i] && !push[i]) ovr[i] <= 1'b1;
            if (pop[i]) led[i] <= !led[i];
         end

   // tx is the registered image of the state, so every bit is shifted one cycle but keeps its width
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= TX_IDLE;
         bcnt <= '0;
         idx <= '0;
         sh <= '0;
         dreg <= '0;
         rr_last <= CH2;
         tx <= 1'b1;
      end else begin
         tx <= tx_bit;
         bcnt <= (grant || tick || st == TX_IDLE) ? '0 : bcnt + 1'b1;
         if (grant) begin
            st <= TX_HDR_START;
            sh <= si ? HDR_CH2 : HDR_CH1;
            dreg <= mem[si][rp[si]];
            rr_last <= sel;
         end else if (tick)
            case (st)
               TX_HDR_START: st <= TX_HDR_DATA;
               TX_HDR_DATA: begin
                  sh <= sh >> 1;
                  idx <= idx + 1'b1;
                  if (idx == 3'd7) st <= TX_HDR_STOP;
               end
               TX_HDR_STOP: begin
                  st <= TX_D_START;
                  sh <= dreg;
               end
               TX_D_START: st <= TX_D_DATA;
               TX_D_DATA: begin
                  sh <= sh >> 1;
                  idx <= idx + 1'b1;
                  if (idx == 3'd7) st <= TX_D_STOP;
               end
               default: st <= TX_IDLE;
            endcase
      end
endmodule

// File: tb/tb_dual_rx_merger.sv
// tb_dual_rx_merger: directed and randomized checks of dual_rx_merger against a frame-level model
module tb_dual_rx_merger;
   localparam int CPB = 8;
   localparam logic [7:0] HDR1 = 8'hA1;
   localparam logic [7:0] HDR2 = 8'hA2;
   logic clk = 1'b0, rst = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic tx, led_ch1, led_ch2, overrun1, overrun2;
   int checks = 0, failures = 0, cyc = 0, tog2 = 0, rr = 2;
   logic m1 = 1'b0, m2 = 1'b0, l2q = 1'b0;
   logic [8:0] got [$];
   int gst [$];

   dual_rx_merger #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx1(rx1), .rx2(rx2), .tx(tx),
      .led_ch1(led_ch1), .led_ch2(led_ch2), .overrun1(overrun1), .overrun2(overrun2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (!rst && led_ch2 !== l2q) tog2++;
      l2q = led_ch2;
   end

   // UART decoder on tx: records {stop, byte} and the cycle its start bit was first seen
   initial begin : mon
      logic [8:0] v;
      logic bad;
      int sc;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            sc = cyc;
            repeat (CPB / 2) @(negedge clk);
            bad = rst | tx;
            for (int i = 0; i < 9; i++) begin
               repeat (CPB) @(negedge clk);
               v[i] = tx;
               bad = bad | rst;
            end
            if (bad === 1'b0) begin
               got.push_back(v);
               gst.push_back(sc);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int ch, input logic [7:0] d, input logic stp);
      logic [9:0] f;
      f = {stp, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (ch == 1) rx1 = f[i]; else rx2 = f[i];
         repeat (CPB) @(negedge clk);
      end
      if (ch == 1) rx1 = 1'b1; else rx2 = 1'b1;
   endtask

   task automatic wait_bytes(input int n);
      for (int i = 0; i < 400 * CPB && got.size() < n; i++) @(negedge clk);
      chk("byte_count", got.size(), n);
   endtask

   task automatic quiet(input int bits, input string tag);
      int lows;
      lows = 0;
      repeat (bits * CPB) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk(tag, lows, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      got.delete();
      gst.delete();
      rr = 2;
      m1 = 1'b0;
      m2 = 1'b0;
   endtask

   task automatic expect_frame(input int k, input logic [7:0] h, input logic [7:0] d);
      if (got.size() >= 2 * k + 2) begin
         chk("hdr_byte", 32'(got[2*k]), {23'd0, 1'b1, h});
         chk("data_byte", 32'(got[2*k+1]), {23'd0, 1'b1, d});
         chk("hdr_to_data_gap", gst[2*k+1] - gst[2*k], 10 * CPB);
      end
   endtask

   // mode 0: ch1 only, 1: ch2 only, 2: both with the same stop edge (served in round-robin order)
   task automatic run_case(input int mode, input logic [7:0] d1, input logic [7:0] d2);
      if (mode == 0) begin
         send(1, d1, 1'b1);
         wait_bytes(2);
         expect_frame(0, HDR1, d1);
         rr = 1;
         m1 = ~m1;
      end else if (mode == 1) begin
         send(2, d2, 1'b1);
         wait_bytes(2);
         expect_frame(0, HDR2, d2);
         rr = 2;
         m2 = ~m2;
      end else begin
         fork
            send(1, d1, 1'b1);
            send(2, d2, 1'b1);
         join
         wait_bytes(4);
         if (rr == 2) begin
            expect_frame(0, HDR1, d1);
            expect_frame(1, HDR2, d2);
         end else begin
            expect_frame(0, HDR2, d2);
            expect_frame(1, HDR1, d1);
         end
         if (gst.size() >= 3) chk("frame_gap", gst[2] - gst[0], 20 * CPB);
         m1 = ~m1;
         m2 = ~m2;
      end
      chk("led_ch1", 32'(led_ch1), 32'(m1));
      chk("led_ch2", 32'(led_ch2), 32'(m2));
      repeat (CPB) @(negedge clk);
      got.delete();
      gst.delete();
   endtask

   initial begin
      int n, prev;
      logic inc_ok, hdr_ok;
      repeat (2) @(negedge clk);
      chk("reset_tx", 32'(tx), 1);
      chk("reset_led1", 32'(led_ch1), 0);
      chk("reset_led2", 32'(led_ch2), 0);
      chk("reset_ovr1", 32'(overrun1), 0);
      chk("reset_ovr2", 32'(overrun2), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      run_case(0, 8'h55, 8'h00);
      do_reset();
      run_case(2, 8'h11, 8'h22);
      run_case(2, 8'h33, 8'h44);

      send(1, 8'h3C, 1'b0);
      quiet(40, "framing_quiet");
      chk("framing_led1", 32'(led_ch1), 32'(m1));
      chk("framing_nobytes", got.size(), 0);
      run_case(0, 8'h3D, 8'h00);

      @(negedge clk);
      rx1 = 1'b0;
      repeat (2) @(negedge clk);
      rx1 = 1'b1;
      quiet(20, "glitch_quiet");
      chk("glitch_led1", 32'(led_ch1), 32'(m1));
      chk("glitch_nobytes", got.size(), 0);

      do_reset();
      for (int it = 0; it < 10; it++)
         run_case(int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      do_reset();
      tog2 = 0;
      for (int k = 0; k < 12; k++) send(2, 8'(k), 1'b1);
      repeat (120 * CPB) @(negedge clk);
      n = got.size() / 2;
      prev = -1;
      inc_ok = 1'b1;
      hdr_ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (got[2*i] !== {1'b1, HDR2}) hdr_ok = 1'b0;
         if (got[2*i+1][8] !== 1'b1 || int'(got[2*i+1][7:0]) <= prev) inc_ok = 1'b0;
         prev = int'(got[2*i+1][7:0]);
      end
      chk("ovr_flag2", 32'(overrun2), 1);
      chk("ovr_flag1", 32'(overrun1), 0);
      chk("ovr_headers", 32'(hdr_ok), 1);
      chk("ovr_increasing", 32'(inc_ok), 1);
      chk("ovr_count_vs_led", n, tog2);
      chk("ovr_some_dropped", 32'(n < 12 && n > 0), 1);
      if (n > 0) chk("ovr_first", 32'(got[1]), 32'h100);

      do_reset();
      fork
         send(1, 8'h5A, 1'b1);
      join_none
      for (int i = 0; i < 40 * CPB && tx !== 1'b0; i++) @(negedge clk);
      chk("hdr_start_seen", 32'(tx), 0);
      repeat (2 * CPB) @(negedge clk);
      chk("hdr_bit1_low", 32'(tx), 0);
      chk("pre_reset_led1", 32'(led_ch1), 1);
      rst = 1'b1;
      #1;
      chk("midframe_reset_tx", 32'(tx), 1);
      chk("midframe_reset_led1", 32'(led_ch1), 0);
      chk("midframe_reset_led2", 32'(led_ch2), 0);
      repeat (20) @(negedge clk);
      rst = 1'b0;
      rr = 2;
      m1 = 1'b0;
      m2 = 1'b0;
      quiet(40, "post_reset_quiet");
      chk("post_reset_nobytes", got.size(), 0);
      run_case(0, 8'hC3, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
